operand_forward_pipe: RTL and testbench

Result-return path of the integer pipeline. It carries the ALU/load result from EX through the MEM and WB pipeline registers and drives the register-file write port. It also forwards in-flight results back to the operand inputs of the instruction in ID, and raises a load-use stall. Its operandA/operandB outputs feed the ALU operand-source multiplexer for the next instruction.

---
 rtl/operand_forward_pipe.sv | 138 +++++++++++++
 tb/tb_operand_forward_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/operand_forward_pipe.sv
// Result-return path: EX -> MEM -> WB pipeline registers driving the register-file
// write port, with per-source operand forwarding and load-use stall detection.

// Forwarding mux for one ID source operand; also flags a load-use hit on that source.
module operand_forward_lane #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_prod,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_prod,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic              wb_prod,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] operand,
  output logic              hazard
);
  logic rs_nz, ex_hit, mem_hit, wb_hit;

  assign rs_nz   = |rs;
  assign ex_hit  = ex_prod  & (ex_rd  == rs) & rs_nz;
  assign mem_hit = mem_prod & (mem_rd == rs) & rs_nz;
  assign wb_hit  = wb_prod  & (wb_rd  == rs) & rs_nz;
  assign hazard  = ex_hit & ex_is_load;

  // A load hit in EX falls through to older stages; the value is discarded by the stall.
  always_comb begin
    operand = rf_rdata;
    if (!rs_nz)                    operand = '0;
    else if (ex_hit & ~ex_is_load) operand = ex_result;
    else if (mem_hit)              operand = mem_fwd;
    else if (wb_hit)               operand = wb_data;
  end
endmodule

module operand_forward_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] operandA,
  output logic [DATA_W-1:0] operandB,
  output logic              stall,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  localparam int NUM_SRC = 2;
  localparam int STAGES  = 2;

  typedef struct packed {
    logic              wen;
    logic              is_load;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } mem_t;

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;
  mem_t             mem_q;
  wb_t              wb_q;
  logic [DATA_W-1:0] mem_fwd;

  // Bit 0 is the EX slot as it will be captured: a flushed EX never enters MEM.
  assign vld_pipe = {vld_q, ex_valid & ~flush};
  assign mem_fwd  = mem_q.is_load ? mem_load_data : mem_q.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      mem_q <= '{wen: ex_wen, is_load: ex_is_load, rd: ex_rd, data: ex_result};
      wb_q  <= '{wen: mem_q.wen, rd: mem_q.rd, data: mem_fwd};
    end
  end

  assign wb_wen  = vld_pipe[2] & wb_q.wen & (|wb_q.rd);
  assign wb_rd   = wb_q.rd;
  assign wb_data = wb_q.data;

  logic [NUM_SRC-1:0][REG_AW-1:0] rs;
  logic [NUM_SRC-1:0][DATA_W-1:0] rf, opnd;
  logic [NUM_SRC-1:0]             hazard;

  assign rs = {id_rs2, id_rs1};
  assign rf = {rf_rdata2, rf_rdata1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    operand_forward_lane #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_lane (
      .rs         (rs[g]),
      .ex_prod    (ex_valid & ex_wen),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .ex_result  (ex_result),
      .mem_prod   (vld_pipe[1] & mem_q.wen),
      .mem_rd     (mem_q.rd),
      .mem_fwd    (mem_fwd),
      .wb_prod    (vld_pipe[2] & wb_q.wen),
      .wb_rd      (wb_q.rd),
      .wb_data    (wb_q.data),
      .rf_rdata   (rf[g]),
      .operand    (opnd[g]),
      .hazard     (hazard[g])
    );
  end

  assign operandA = opnd[0];
  assign operandB = opnd[1];
  assign stall    = id_valid & ~flush & (|hazard);
endmodule

// File: tb/tb_operand_forward_pipe.sv
// Scoreboard bench: stimulus queues expected operands/stall and register writes;
// monitors on the falling edge pop and compare.
module tb_operand_forward_pipe;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        ex_valid = 0, ex_wen = 0, ex_is_load = 0, id_valid = 0;
  logic [4:0]  ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
  logic [31:0] ex_result = 0, mem_load_data = 0, rf_rdata1 = 0, rf_rdata2 = 0;
  logic [31:0] operandA, operandB, wb_data;
  logic [4:0]  wb_rd;
  logic        stall, wb_wen;

  operand_forward_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_load_data(mem_load_data), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .operandA(operandA), .operandB(operandB),
    .stall(stall), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ca, cb, cwb, st, wen;
    logic [31:0] a, b, wd;
  } op_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_exp_t;

  op_exp_t op_q[$];
  wr_exp_t wr_q[$];
  int n_chk = 0, n_pass = 0;
  bit done = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  // Drive one cycle of inputs just after the rising edge.
  task automatic cyc(input bit r, input bit fl, input bit exv, input bit wen, input bit ld,
                     input logic [4:0] rd, input logic [31:0] res, input logic [31:0] ldd,
                     input bit idv, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] rf1, input logic [31:0] rf2);
    @(posedge clk); #1;
    rst_n = r; flush = fl; ex_valid = exv; ex_wen = wen; ex_is_load = ld; ex_rd = rd;
    ex_result = res; mem_load_data = ldd; id_valid = idv; id_rs1 = r1; id_rs2 = r2;
    rf_rdata1 = rf1; rf_rdata2 = rf2;
  endtask

  task automatic exp_op(input string nm, input bit ca, input logic [31:0] a,
                        input bit cb, input logic [31:0] b, input bit st);
    op_q.push_back('{name: nm, ca: ca, cb: cb, cwb: 1'b0, st: st, wen: 1'b0, a: a, b: b, wd: 32'h0});
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    wr_q.push_back('{rd: rd, data: d});
  endtask

  // Operand / stall monitor.
  always @(negedge clk) begin
    if (op_q.size() > 0) begin
      op_exp_t e;
      e = op_q.pop_front();
      chk({e.name, ".stall"}, stall, e.st);
      if (e.ca) chk({e.name, ".opA"}, operandA, e.a);
      if (e.cb) chk({e.name, ".opB"}, operandB, e.b);
      if (e.cwb) begin
        chk({e.name, ".wb_wen"}, wb_wen, e.wen);
        chk({e.name, ".wb_data"}, wb_data, e.wd);
      end
    end
  end

  // Register-file write monitor: every issued write must match the next expected one.
  always @(negedge clk) begin
    if (wb_wen && !done) begin
      if (wr_q.size() == 0) chk("wb_unexpected_write", {27'h0, wb_rd}, 64'hFFFF);
      else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        chk("wb_rd", wb_rd, w.rd);
        chk("wb_data", wb_data, w.data);
      end
    end
  end

  initial begin
    // Reset: no writes, operands from rf or zero.
    cyc(0,0, 0,0,0, 0,0,0, 1, 2,0, 32'h22,32'h99);
    op_q.push_back('{name: "reset", ca: 1, cb: 1, cwb: 1, st: 0, wen: 0, a: 32'h22, b: 32'h0, wd: 32'h0});
    cyc(1,0, 0,0,0, 0,0,0, 0, 0,0, 0,0);                         exp_op("rel", 0,0, 0,0, 0);

    // Back-to-back ALU dependency on r5.
    cyc(1,0, 1,1,0, 5,32'h11,0, 1, 5,6, 32'h500,32'h600);        exp_op("b2b_ex", 1,32'h11, 1,32'h600, 0);
    exp_wr(5, 32'h11);
    cyc(1,0, 0,0,0, 0,0,0, 1, 5,0, 32'h500,32'h600);             exp_op("b2b_mem", 1,32'h11, 1,0, 0);
    cyc(1,0, 0,0,0, 0,0,0, 1, 5,0, 32'h500,32'h600);             exp_op("b2b_wb", 1,32'h11, 0,0, 0);
    cyc(1,0, 0,0,0, 0,0,0, 1, 5,0, 32'h77,32'h0);                exp_op("b2b_rf", 1,32'h77, 0,0, 0);

    // Priority: EX > MEM > WB on r3.
    cyc(1,0, 1,1,0, 3,32'hC,0, 0, 0,0, 0,0);                     exp_op("pri_p1", 0,0, 0,0, 0); exp_wr(3, 32'hC);
    cyc(1,0, 1,1,0, 3,32'hB,0, 0, 0,0, 0,0);                     exp_op("pri_p2", 0,0, 0,0, 0); exp_wr(3, 32'hB);
    cyc(1,0, 1,1,0, 3,32'hA,0, 1, 3,3, 32'h3333,32'h3333);       exp_op("pri_ex", 1,32'hA, 1,32'hA, 0); exp_wr(3, 32'hA);
    cyc(1,0, 1,1,0, 3,32'hC,0, 0, 0,0, 0,0);                     exp_op("pri_p4", 0,0, 0,0, 0); exp_wr(3, 32'hC);
    cyc(1,0, 1,1,0, 3,32'hB,0, 0, 0,0, 0,0);                     exp_op("pri_p5", 0,0, 0,0, 0); exp_wr(3, 32'hB);
    cyc(1,0, 0,0,0, 0,0,0, 1, 3,3, 32'h3333,32'h3333);           exp_op("pri_mem", 1,32'hB, 1,32'hB, 0);
    cyc(1,0, 0,0,0, 0,0,0, 1, 3,3, 32'h3333,32'h3333);           exp_op("pri_wb_only", 1,32'hB, 1,32'hB, 0);
    cyc(1,0, 1,1,0, 3,32'hC,0, 0, 0,0, 0,0);                     exp_op("pri_p8", 0,0, 0,0, 0); exp_wr(3, 32'hC);
    cyc(1,0, 0,0,0, 0,0,0, 1, 3,3, 32'h3333,32'h3333);           exp_op("pri_mem2", 1,32'hC, 1,32'hC, 0);
    cyc(1,0, 0,0,0, 0,0,0, 1, 3,3, 32'h3333,32'h3333);           exp_op("pri_wb", 1,32'hC, 1,32'hC, 0);

    // Load-use on r7.
    cyc(1,0, 1,1,1, 7,32'h1234,0, 1, 1,7, 32'h100,32'h700);      exp_op("lu_stall", 1,32'h100, 0,0, 1);
    exp_wr(7, 32'hDEADBEEF);
    cyc(1,0, 0,0,0, 0,0,32'hDEADBEEF, 1, 1,7, 32'h100,32'h700);  exp_op("lu_mem", 1,32'h100, 1,32'hDEADBEEF, 0);
    cyc(1,0, 0,0,0, 0,0,32'h0, 1, 1,7, 32'h100,32'h700);         exp_op("lu_wb", 1,32'h100, 1,32'hDEADBEEF, 0);

    // Register 0 never forwards, writes, or stalls.
    cyc(1,0, 1,1,0, 0,32'h55,0, 0, 0,0, 0,0);                    exp_op("r0_p1", 0,0, 0,0, 0);
    cyc(1,0, 1,1,0, 0,32'h55,0, 0, 0,0, 0,0);                    exp_op("r0_p2", 0,0, 0,0, 0);
    cyc(1,0, 1,1,1, 0,32'h55,32'h55, 1, 0,0, 32'h55,32'h55);     exp_op("r0_all", 1,0, 1,0, 0);
    cyc(1,0, 0,0,0, 0,0,32'h55, 1, 0,0, 32'h55,32'h55);          exp_op("r0_drain", 1,0, 1,0, 0);
    cyc(1,0, 0,0,0, 0,0,0, 0, 0,0, 0,0);                         exp_op("r0_drain2", 0,0, 0,0, 0);

    // Flush: no capture, no stall.
    cyc(1,1, 1,1,0, 4,32'h44,0, 0, 0,0, 0,0);                    exp_op("fl_ex", 0,0, 0,0, 0);
    cyc(1,0, 0,0,0, 0,0,0, 1, 4,0, 32'h400,0);                   exp_op("fl_mem", 1,32'h400, 0,0, 0);
    cyc(1,0, 0,0,0, 0,0,0, 1, 4,0, 32'h400,0);                   exp_op("fl_wb", 1,32'h400, 0,0, 0);
    cyc(1,1, 1,1,1, 4,32'h44,0, 1, 4,0, 32'h400,0);              exp_op("fl_load", 0,0, 0,0, 0);
    cyc(1,0, 0,0,0, 0,0,32'h4444, 1, 4,0, 32'h400,0);            exp_op("fl_load_mem", 1,32'h400, 0,0, 0);

    // Reset mid-flight discards MEM/WB.
    cyc(1,0, 1,1,0, 9,32'h99,0, 0, 0,0, 0,0);                    exp_op("rm_p1", 0,0, 0,0, 0);
    cyc(1,0, 1,1,0, 10,32'hAA,0, 0, 0,0, 0,0);                   exp_op("rm_p2", 0,0, 0,0, 0);
    cyc(0,0, 0,0,0, 0,0,0, 1, 9,0, 32'h900,0);
    op_q.push_back('{name: "rm_reset", ca: 1, cb: 0, cwb: 1, st: 0, wen: 0, a: 32'h900, b: 32'h0, wd: 32'h0});
    cyc(1,0, 0,0,0, 0,0,0, 1, 10,0, 32'hA00,0);
    op_q.push_back('{name: "rm_release", ca: 1, cb: 0, cwb: 1, st: 0, wen: 0, a: 32'hA00, b: 32'h0, wd: 32'h0});
    repeat (3) begin
      cyc(1,0, 0,0,0, 0,0,0, 0, 0,0, 0,0);                       exp_op("drain", 0,0, 0,0, 0);
    end
    @(posedge clk); #1;
    done = 1;
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_ops", op_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
